// File: rtl/compute_clock_gate_ctrl.sv
// compute_clock_gate_ctrl
//
// Generates the registered enable for the compute clock buffer. An accepted start runs the
// compute domain for a programmed number of root_clock cycles. The enable stays low for an arm
// delay before the run and for a flush delay after it. A stall request pauses the budget and a
// stop request aborts the run. Completion, abort status and cycle counts go to the host.
//
// Parameters
//   CNT_W        width of cycle_budget, elapsed_cycles and stall_cycles
//   ARM_CYCLES   cycles with the enable low between start accept and first enabled cycle (>=1)
//   FLUSH_CYCLES cycles with the enable low after the last enabled cycle, before done (>=1)
//
// Ports
//   root_clock        clock for all logic
//   reset_n_trigger   asynchronous active-low reset
//   start             single-cycle request, accepted only when idle
//   cycle_budget      number of enabled cycles, sampled with an accepted start
//   stall_req         level, pauses the run
//   stop_req          level, aborts the run
//   compute_clock_en  registered enable to the compute clock buffer
//   busy              high from start accept until done
//   done              one-cycle completion pulse
//   stopped           last run was aborted by stop_req
//   elapsed_cycles    enabled cycles completed in the current or last run
//   stall_cycles      stalled cycles in the current or last run, saturating

module compute_clock_gate_ctrl #(
  parameter int unsigned CNT_W        = 48,
  parameter int unsigned ARM_CYCLES   = 2,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic             root_clock,
  input  logic             reset_n_trigger,
  input  logic             start,
  input  logic [CNT_W-1:0] cycle_budget,
  input  logic             stall_req,
  input  logic             stop_req,
  output logic             compute_clock_en,
  output logic             busy,
  output logic             done,
  output logic             stopped,
  output logic [CNT_W-1:0] elapsed_cycles,
  output logic [CNT_W-1:0] stall_cycles
);

  // One delay counter serves both ARM and FLUSH. It restarts at zero on entry to either state.
  localparam int unsigned DlyMax = (ARM_CYCLES > FLUSH_CYCLES) ? ARM_CYCLES : FLUSH_CYCLES;
  localparam int unsigned DlyW   = (DlyMax > 1) ? $clog2(DlyMax) : 1;

  localparam logic [DlyW-1:0] ArmLast   = DlyW'(ARM_CYCLES - 1);
  localparam logic [DlyW-1:0] FlushLast = DlyW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StStall,
    StFlush,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [DlyW-1:0]  dly_q, dly_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stopped_q, stopped_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] elapsed_inc;

  assign elapsed_inc = elapsed_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    dly_d     = '0;
    budget_d  = budget_q;
    elapsed_d = elapsed_q;
    stall_d   = stall_q;
    stopped_d = stopped_q;
    busy_d    = busy_q;
    // Enable and done are only raised explicitly on the paths that need them.
    en_d      = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          budget_d  = cycle_budget;
          elapsed_d = '0;
          stall_d   = '0;
          stopped_d = 1'b0;
          busy_d    = 1'b1;
          // A zero budget never enables the clock and still flushes before done.
          state_d   = (cycle_budget == '0) ? StFlush : StArm;
        end
      end

      StArm: begin
        if (stop_req) begin
          state_d   = StFlush;
          stopped_d = 1'b1;
        end else if (dly_q == ArmLast) begin
          state_d = StRun;
          en_d    = 1'b1;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end

      StRun: begin
        // The enable is high for the whole of every RUN cycle.
        elapsed_d = elapsed_inc;
        if (elapsed_inc == budget_q) begin
          // Exhaustion wins over a simultaneous stop, so the run is not reported as aborted.
          state_d = StFlush;
        end else if (stop_req) begin
          state_d   = StFlush;
          stopped_d = 1'b1;
        end else if (stall_req) begin
          state_d = StStall;
        end else begin
          en_d = 1'b1;
        end
      end

      StStall: begin
        if (stall_q != '1) begin
          stall_d = stall_q + CNT_W'(1);
        end
        if (stop_req) begin
          state_d   = StFlush;
          stopped_d = 1'b1;
        end else if (!stall_req) begin
          state_d = StRun;
          en_d    = 1'b1;
        end
      end

      StFlush: begin
        if (dly_q == FlushLast) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge root_clock or negedge reset_n_trigger) begin
    if (!reset_n_trigger) begin
      state_q   <= StIdle;
      dly_q     <= '0;
      budget_q  <= '0;
      elapsed_q <= '0;
      stall_q   <= '0;
      stopped_q <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      budget_q  <= budget_d;
      elapsed_q <= elapsed_d;
      stall_q   <= stall_d;
      stopped_q <= stopped_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Every output comes straight from a flop, so the clock buffer enable cannot glitch.
  assign compute_clock_en = en_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign stopped          = stopped_q;
  assign elapsed_cycles   = elapsed_q;
  assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_compute_clock_gate_ctrl.sv
module tb_compute_clock_gate_ctrl;

  localparam int ARM   = 2;
  localparam int FLUSH = 4;

  logic        root_clock = 1'b0;
  logic        reset_n_trigger = 1'b0;
  logic        start = 1'b0;
  logic [47:0] cycle_budget = '0;
  logic        stall_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        compute_clock_en, busy, done, stopped;
  logic [47:0] elapsed_cycles, stall_cycles;

  // Narrow instance for the saturation and maximum-budget boundaries.
  logic        s_start = 1'b0;
  logic [2:0]  s_budget = '0;
  logic        s_stall = 1'b0;
  logic        s_stop = 1'b0;
  logic        s_en, s_busy, s_done, s_stopped;
  logic [2:0]  s_elapsed, s_stalls;

  int n_checks = 0;
  int n_errors = 0;

  always #5 root_clock = ~root_clock;

  compute_clock_gate_ctrl #(.CNT_W(48), .ARM_CYCLES(ARM), .FLUSH_CYCLES(FLUSH)) dut (
    .root_clock      (root_clock),
    .reset_n_trigger (reset_n_trigger),
    .start           (start),
    .cycle_budget    (cycle_budget),
    .stall_req       (stall_req),
    .stop_req        (stop_req),
    .compute_clock_en(compute_clock_en),
    .busy            (busy),
    .done            (done),
    .stopped         (stopped),
    .elapsed_cycles  (elapsed_cycles),
    .stall_cycles    (stall_cycles)
  );

  compute_clock_gate_ctrl #(.CNT_W(3), .ARM_CYCLES(ARM), .FLUSH_CYCLES(FLUSH)) dut_small (
    .root_clock      (root_clock),
    .reset_n_trigger (reset_n_trigger),
    .start           (s_start),
    .cycle_budget    (s_budget),
    .stall_req       (s_stall),
    .stop_req        (s_stop),
    .compute_clock_en(s_en),
    .busy            (s_busy),
    .done            (s_done),
    .stopped         (s_stopped),
    .elapsed_cycles  (s_elapsed),
    .stall_cycles    (s_stalls)
  );

  // Per-edge request levels, indexed by edge number counted from the start edge (0).
  bit stall_a [256];
  bit stop_a  [256];

  // Reference results for one run.
  bit          m_en [256];
  int          m_done;
  logic [47:0] m_elapsed;
  logic [47:0] m_stalls;
  bit          m_stopped;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 256; i++) begin
      stall_a[i] = 1'b0;
      stop_a[i]  = 1'b0;
    end
  endtask

  // Walks the run edge by edge in terms of "enabled" and "paused" cycles and records where the
  // enable is high, when done must pulse and the final counts.
  task automatic model_run(input logic [47:0] budget);
    int  t;
    int  endt;
    bit  paused;
    for (int i = 0; i < 256; i++) m_en[i] = 1'b0;
    m_elapsed = '0;
    m_stalls  = '0;
    m_stopped = 1'b0;
    endt      = -1;
    if (budget == '0) begin
      endt = 0;
    end else begin
      for (int a = 1; a <= ARM; a++) begin
        if (endt < 0 && stop_a[a]) begin
          endt      = a;
          m_stopped = 1'b1;
        end
      end
      if (endt < 0) begin
        paused = 1'b0;
        t      = ARM;
        while (endt < 0 && t < 240) begin
          m_en[t] = !paused;
          t++;
          if (!paused) begin
            m_elapsed++;
            if (m_elapsed == budget) endt = t;
            else if (stop_a[t]) begin endt = t; m_stopped = 1'b1; end
            else if (stall_a[t]) paused = 1'b1;
          end else begin
            m_stalls++;
            if (stop_a[t]) begin endt = t; m_stopped = 1'b1; end
            else if (!stall_a[t]) paused = 1'b0;
          end
        end
      end
    end
    m_done = endt + FLUSH;
  endtask

  // Caller is at a negedge with the DUT idle.
  task automatic run_dut(input string tag, input logic [47:0] budget);
    model_run(budget);
    start        = 1'b1;
    cycle_budget = budget;
    stall_req    = 1'b0;
    stop_req     = 1'b0;
    @(posedge root_clock);
    @(negedge root_clock);
    start = 1'b0;
    for (int t = 0; t <= m_done + 1; t++) begin
      if (t > 0) begin
        @(posedge root_clock);
        @(negedge root_clock);
      end
      chk({tag, "_en"}, compute_clock_en, m_en[t]);
      if (t < m_done) begin
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_nodone"}, done, 1'b0);
      end else if (t == m_done) begin
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_done"}, busy, 1'b0);
        chk({tag, "_elapsed"}, elapsed_cycles, m_elapsed);
        chk({tag, "_stalls"}, stall_cycles, m_stalls);
        chk({tag, "_stopped"}, stopped, m_stopped);
      end else begin
        chk({tag, "_done_once"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_hold_elapsed"}, elapsed_cycles, m_elapsed);
      end
      if (t + 1 <= m_done + 1) begin
        stall_req = stall_a[t + 1];
        stop_req  = stop_a[t + 1];
        // Stray starts while busy must be ignored.
        start        = ($urandom_range(0, 15) == 0);
        cycle_budget = 48'($urandom_range(1, 30));
      end else begin
        stall_req = 1'b0;
        stop_req  = 1'b0;
        start     = 1'b0;
      end
    end
  endtask

  initial begin
    int en_cnt;
    bit seen;

    // Reset state
    #2;
    chk("rst_en", compute_clock_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stopped", stopped, 1'b0);
    chk("rst_elapsed", elapsed_cycles, 48'd0);
    chk("rst_stalls", stall_cycles, 48'd0);
    @(negedge root_clock);
    @(negedge root_clock);
    reset_n_trigger = 1'b1;
    @(negedge root_clock);

    // Directed cases
    clear_reqs();
    run_dut("b5", 48'd5);
    chk("b5_elapsed_const", elapsed_cycles, 48'd5);

    clear_reqs();
    run_dut("b0", 48'd0);
    chk("b0_elapsed_const", elapsed_cycles, 48'd0);

    clear_reqs();
    stall_a[6] = 1'b1; stall_a[7] = 1'b1; stall_a[8] = 1'b1;
    run_dut("b10_stall", 48'd10);
    chk("b10_stall_const", stall_cycles, 48'd3);
    chk("b10_elapsed_const", elapsed_cycles, 48'd10);

    clear_reqs();
    for (int i = 9; i < 40; i++) stop_a[i] = 1'b1;
    run_dut("b100_stop", 48'd100);
    chk("b100_stopped_const", stopped, 1'b1);
    chk("b100_elapsed_const", elapsed_cycles, 48'd7);

    clear_reqs();
    stop_a[7] = 1'b1;
    run_dut("b5_stop_last", 48'd5);
    chk("b5_stop_last_const", stopped, 1'b0);

    clear_reqs();
    stop_a[1] = 1'b1;
    run_dut("stop_arm", 48'd3);

    clear_reqs();
    stall_a[4] = 1'b1; stall_a[5] = 1'b1; stop_a[5] = 1'b1;
    run_dut("stop_stall", 48'd8);

    // Randomised runs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 256; i++) begin
        stall_a[i] = (i < 150) && ($urandom_range(0, 3) == 0);
        stop_a[i]  = ($urandom_range(0, 39) == 0);
      end
      run_dut($sformatf("rnd%0d", r), 48'($urandom_range(0, 20)));
    end

    // Reset while the enable is high
    clear_reqs();
    start = 1'b1;
    cycle_budget = 48'd50;
    @(posedge root_clock);
    @(negedge root_clock);
    start = 1'b0;
    repeat (6) @(negedge root_clock);
    chk("mid_en_before", compute_clock_en, 1'b1);
    #2 reset_n_trigger = 1'b0;
    #1;
    chk("mid_rst_en", compute_clock_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_elapsed", elapsed_cycles, 48'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge root_clock);
      if (done) seen = 1'b1;
    end
    reset_n_trigger = 1'b1;
    repeat (10) begin
      @(negedge root_clock);
      if (done) seen = 1'b1;
    end
    chk("mid_rst_no_done", seen, 1'b0);
    run_dut("after_rst", 48'd5);

    // Narrow instance: stall count saturates at all-ones
    s_start  = 1'b1;
    s_budget = 3'd2;
    @(posedge root_clock);
    @(negedge root_clock);
    s_start = 1'b0;
    s_stall = 1'b1;
    repeat (14) @(negedge root_clock);
    s_stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge root_clock);
      if (s_done) seen = 1'b1;
    end
    chk("sat_done_seen", seen, 1'b1);
    chk("sat_stalls", s_stalls, 3'd7);
    chk("sat_elapsed", s_elapsed, 3'd2);
    @(negedge root_clock);

    // Narrow instance: maximum budget
    s_start  = 1'b1;
    s_budget = 3'd7;
    @(posedge root_clock);
    @(negedge root_clock);
    s_start = 1'b0;
    seen    = 1'b0;
    en_cnt  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge root_clock);
      if (s_en) en_cnt++;
      if (s_done) seen = 1'b1;
    end
    chk("max_done_seen", seen, 1'b1);
    chk("max_en_cycles", 64'(en_cnt), 64'd7);
    chk("max_elapsed", s_elapsed, 3'd7);
    chk("max_stopped", s_stopped, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
